// File: rtl/al_map_pkg.sv
// Shared constants and helpers for the Anlogic mapped-primitive simulation models.
// Latency: none (package only).
// Backpressure: not applicable.
package al_map_pkg;

  // rd_data reset/init encodings selected by the REGSET string parameter
  localparam int AL_REGSET_RESET = 0;
  localparam int AL_REGSET_SET   = 1;

  // Entries held by one LUT6 distributed-RAM column
  localparam int AL_DRAM_COL_DEPTH = 64;

  // Pointers carry one extra wrap bit above the address so full and empty differ
  function automatic int al_ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/al_map_dram.sv
// Distributed LUT-RAM storage: synchronous write on clk, asynchronous read.
// Latency: write visible on read port after the write edge; read is combinational.
// Backpressure: none; the caller decides when a write is allowed. No reset, contents persist.
module al_map_dram #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  // Single write port, clock-enabled by we
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/al_map_dram_fifo.sv
// Synchronous FIFO model on distributed RAM with a clock-enabled output register (optional AL_MAP_FIFO_ALMOST_EN adds almost_full/almost_empty).
// Latency: 1 cycle from accepted rd_en to rd_valid/rd_data; a write is readable the cycle after it is accepted.
// Backpressure: writes at full and reads at empty are dropped and flagged with one-cycle wr_ovf/rd_unf pulses.
module al_map_dram_fifo
  import al_map_pkg::*;
#(
  parameter int    WIDTH      = 8,
  parameter int    DEPTH_LOG2 = 6,
  parameter string REGSET     = "RESET",
  parameter int    AF_THR     = (1 << DEPTH_LOG2) - 4,
  parameter int    AE_THR     = 4
) (
  input  logic                  clk,
  input  logic                  sr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  wr_ovf,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  rd_unf,
  output logic [DEPTH_LOG2:0]   count
`ifdef AL_MAP_FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int PW = al_ptr_w(DEPTH_LOG2);
  localparam int REGSET_ENC = (REGSET == "SET") ? AL_REGSET_SET : AL_REGSET_RESET;
  localparam logic [WIDTH-1:0] RD_INIT = (REGSET_ENC == AL_REGSET_SET) ? '1 : '0;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]    wptr, rptr;
  logic [PW-1:0]    wptr_nxt, rptr_nxt;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  // Flags come straight from the registered pointers, so every accept decision uses pre-edge state
  assign empty  = (wptr == rptr);
  assign full   = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign count  = wptr - rptr;
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign wptr_nxt = wr_acc ? (wptr + PTR_ONE) : wptr;
  assign rptr_nxt = rd_acc ? (rptr + PTR_ONE) : rptr;

  // Read address is the current rptr: a write to a different slot in the same cycle never bypasses
  al_map_dram #(
    .WIDTH (WIDTH),
    .AW    (DEPTH_LOG2)
  ) u_dram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[PW-2:0]),
    .wdata (wr_data),
    .raddr (rptr[PW-2:0]),
    .rdata (ram_rdata)
  );

  // Pointer, status-pulse and output-register state; rd_data only loads on an accepted read
  always_ff @(posedge clk or posedge sr) begin
    if (sr) begin
      wptr     <= '0;
      rptr     <= '0;
      wr_ovf   <= 1'b0;
      rd_unf   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= RD_INIT;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      wr_ovf   <= wr_en && full;
      rd_unf   <= rd_en && empty;
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= ram_rdata;
    end
  end

`ifdef AL_MAP_FIFO_ALMOST_EN
  logic [PW-1:0] cnt_nxt;
  logic [31:0]   cnt_ext;

  assign cnt_nxt = wptr_nxt - rptr_nxt;
  assign cnt_ext = 32'(cnt_nxt);

  // Thresholds evaluated on the post-edge occupancy so the flags change in the same cycle as count
  always_ff @(posedge clk or posedge sr) begin
    if (sr) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (cnt_ext >= AF_THR[31:0]);
      almost_empty <= (cnt_ext <= AE_THR[31:0]);
    end
  end
`endif

endmodule
